decode_pipe_stage: RTL and testbench
====================================

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter NREGS, default 32, number of architectural registers; legal 8..32.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-low (rst=0 resets at next rising edge).
REQ-005 in_valid  input  1  instr holds a valid fetched instruction.
REQ-006 in_ready  output  1  stage accepts instr this cycle.
REQ-007 instr  input  32  MIPS instruction word.
REQ-008 ex_stall  input  1  downstream cannot take ID/EX contents; hold them.
REQ-009 flush  input  1  kill instruction being captured this cycle (branch/jump taken).
REQ-010 wb_en, wb_addr[4:0], wb_data[XLEN-1:0]  inputs  write-back port.
REQ-011 out_valid  output  1  ID/EX register holds a valid instruction.
REQ-012 out_ctrl  output  10  {RegWrite,ALUSrc,MemWrite,MemToReg,MemRead,Branch,Jump,RegDst,ALUOp[1:0]}, MSB first.
REQ-013 out_rd1, out_rd2, out_imm  output  XLEN  operand A, operand B, extended immediate.
REQ-014 out_rs, out_rt, out_rd  output  5  register fields, registered.
REQ-015 hazard_stall  output  1  load-use hazard detected this cycle (combinational).

Function
REQ-016 Register file: NREGS x XLEN; register 0 reads 0, writes to it are ignored; addresses >= NREGS read 0, writes ignored.
REQ-017 Write-back commits on rising edge when wb_en=1; a same-cycle read of wb_addr (nonzero, < NREGS) returns wb_data (write-through bypass).
REQ-018 Decode by opcode instr[31:26]: 0x00 R-type ctrl=1000000110; 0x23 lw 1101100000; 0x2B sw 0110000000; 0x04 beq 0000010001; 0x08 addi 1100000000; 0x02 j 0000001000; any other opcode ctrl=0 (treated as NOP).
REQ-019 out_imm = instr[15:0] sign-extended to XLEN; for j, out_imm = zero-extended instr[25:0].
REQ-020 hazard_stall=1 when out_valid=1, out_ctrl.MemRead=1, out_rt!=0, in_valid=1, and out_rt equals instr[25:21] or instr[20:16].
REQ-021 in_ready = !ex_stall && !hazard_stall.
REQ-022 Capture: when ex_stall=0 the ID/EX register loads the decoded instruction with out_valid=in_valid; latency one cycle from accepted instr to outputs.
REQ-023 Bubble: when ex_stall=0 and hazard_stall=1, ID/EX loads out_valid=0, out_ctrl=0; instr is not consumed and is re-presented by fetch.
REQ-024 Hold: when ex_stall=1 all ID/EX outputs keep their values, including out_valid.
REQ-025 flush=1 with ex_stall=0 loads out_valid=0, out_ctrl=0 regardless of hazard; flush with ex_stall=1 clears out_valid and out_ctrl at that edge (flush dominates stall).
REQ-026 When out_valid=0, out_ctrl SHALL be 0; other data outputs are don't-care but must not be X after reset.

Reset
REQ-027 On rising edge with rst=0: all register-file entries 0, out_valid=0, out_ctrl=0, out_rd1/out_rd2/out_imm=0, out_rs/out_rt/out_rd=0.
REQ-028 Reset dominates flush, ex_stall and wb_en in the same cycle; a write-back presented during reset is discarded.
REQ-029 Reset applied mid-stall or mid-hazard leaves out_valid=0 and hazard_stall=0 one cycle later.

Verification
REQ-030 Reset then wb_en=1, wb_addr=1, wb_data=0x10; instr=0x8C220004 (lw $2,4($1)) -> next cycle out_valid=1, out_ctrl=1101100000, out_rd1=0x10, out_imm=4, out_rt=2.
REQ-031 Follow with instr=0x00432020 (add $4,$2,$3) -> hazard_stall=1, in_ready=0, one bubble (out_valid=0), instruction issued the cycle after.
REQ-032 Same-cycle write/read: wb_addr=5, wb_data=0xABCDEF, instr=0x00A00000 -> out_rd1=0xABCDEF one cycle later.
REQ-033 Write to $0 with 0xFFFF then read $0 -> out_rd1=0; NREGS=8, write $9 then read $9 -> 0.
REQ-034 ex_stall=1 for 3 cycles with flush=1 on the second -> outputs frozen, then out_valid=0 and out_ctrl=0 from the flush edge on.
REQ-035 instr=0x2001FFFC (addi $1,$0,-4) with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFC; opcode 0x3F -> out_ctrl=0.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// MIPS decode stage: register file read with write-through bypass, control decode and ID/EX register.
// One cycle from accepted instr to outputs; ex_stall holds ID/EX, a load-use hazard inserts a bubble and refuses instr.
module decode_pipe_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            ex_stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    output logic [9:0]      out_ctrl,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic            hazard_stall
);

    localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    // ---------------- register file ----------------
    logic [XLEN-1:0] rf_q [NREGS];
    logic            wb_hit;

    assign wb_hit = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREGS_W);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_hit) begin
            rf_q[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    // Port 0 reads rs, port 1 reads rt; a same-cycle write is forwarded.
    logic [1:0][4:0]      rd_addr;
    logic [1:0][XLEN-1:0] rd_val;

    assign rd_addr[0] = instr[25:21];
    assign rd_addr[1] = instr[20:16];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = '0;
            if ((rd_addr[p] != 5'd0) && ({1'b0, rd_addr[p]} < NREGS_W)) begin
                if (wb_en && (wb_addr == rd_addr[p])) begin
                    rd_val[p] = wb_data;
                end else begin
                    rd_val[p] = rf_q[rd_addr[p][AW-1:0]];
                end
            end
        end
    end

    // ---------------- decode ----------------
    logic [5:0]      opcode;
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;

    assign opcode = instr[31:26];

    always_comb begin
        dec_ctrl = '0;
        case (opcode)
            OP_RTYPE: dec_ctrl = 10'b1000000110;
            OP_LW:    dec_ctrl = 10'b1101100000;
            OP_SW:    dec_ctrl = 10'b0110000000;
            OP_BEQ:   dec_ctrl = 10'b0000010001;
            OP_ADDI:  dec_ctrl = 10'b1100000000;
            OP_J:     dec_ctrl = 10'b0000001000;
            default:  dec_ctrl = '0;
        endcase
    end

    always_comb begin
        if (opcode == OP_J) begin
            dec_imm = XLEN'(instr[25:0]);
        end else begin
            dec_imm = {{(XLEN-16){instr[15]}}, instr[15:0]};
        end
    end

    // ---------------- ID/EX register ----------------
    logic            valid_q, valid_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] rd1_q, rd1_d;
    logic [XLEN-1:0] rd2_q, rd2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs_q, rs_d;
    logic [4:0]      rt_q, rt_d;
    logic [4:0]      rdf_q, rdf_d;

    assign hazard_stall = valid_q && ctrl_q.mem_read && (rt_q != 5'd0) && in_valid &&
                          ((rt_q == instr[25:21]) || (rt_q == instr[20:16]));
    assign in_ready     = !ex_stall && !hazard_stall;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rdf_d   = rdf_q;
        if (!ex_stall) begin
            // Data fields load unconditionally; only valid/ctrl distinguish issue from bubble.
            valid_d = in_valid && !hazard_stall && !flush;
            ctrl_d  = valid_d ? dec_ctrl : '0;
            rd1_d   = rd_val[0];
            rd2_d   = rd_val[1];
            imm_d   = dec_imm;
            rs_d    = instr[25:21];
            rt_d    = instr[20:16];
            rdf_d   = instr[15:11];
        end else if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rdf_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rdf_q   <= rdf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_rd1   = rd1_q;
    assign out_rd2   = rd2_q;
    assign out_imm   = imm_q;
    assign out_rs    = rs_q;
    assign out_rt    = rt_q;
    assign out_rd    = rdf_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: two instances (XLEN=32/NREGS=32 and XLEN=64/NREGS=8) share one stimulus stream;
// a transaction-level model fills a scoreboard that a negedge monitor drains as the DUT hands results downstream.
module tb_decode_pipe_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, ex_stall, flush, wb_en;
    logic [31:0] instr;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;

    logic        a_in_ready, a_out_valid, a_hazard;
    logic [9:0]  a_ctrl;
    logic [31:0] a_rd1, a_rd2, a_imm;
    logic [4:0]  a_rs, a_rt, a_rd;

    logic        b_in_ready, b_out_valid, b_hazard;
    logic [9:0]  b_ctrl;
    logic [63:0] b_rd1, b_rd2, b_imm;
    logic [4:0]  b_rs, b_rt, b_rd;

    decode_pipe_stage #(.XLEN(32), .NREGS(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .instr(instr),
        .ex_stall(ex_stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data[31:0]),
        .out_valid(a_out_valid), .out_ctrl(a_ctrl), .out_rd1(a_rd1), .out_rd2(a_rd2), .out_imm(a_imm),
        .out_rs(a_rs), .out_rt(a_rt), .out_rd(a_rd), .hazard_stall(a_hazard)
    );

    decode_pipe_stage #(.XLEN(64), .NREGS(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr),
        .ex_stall(ex_stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(b_out_valid), .out_ctrl(b_ctrl), .out_rd1(b_rd1), .out_rd2(b_rd2), .out_imm(b_imm),
        .out_rs(b_rs), .out_rt(b_rt), .out_rd(b_rd), .hazard_stall(b_hazard)
    );

    typedef struct {
        logic [9:0]  ctrl;
        logic [31:0] rd1a, rd2a, imma;
        logic [63:0] rd1b, rd2b, immb;
        logic [4:0]  rs, rt, rd;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mrf [32];
    bit          occ_v, occ_mr, known, exp_haz, acc;
    logic [4:0]  occ_rt;
    logic        haz_seen, rdy_seen;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 10'b1000000110;
            6'h23:   return 10'b1101100000;
            6'h2B:   return 10'b0110000000;
            6'h04:   return 10'b0000010001;
            6'h08:   return 10'b1100000000;
            6'h02:   return 10'b0000001000;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        if (w[31:26] == 6'h02) return 64'(w[25:0]);
        if (w[15]) return 64'(w[15:0]) - 64'd65536;
        return 64'(w[15:0]);
    endfunction

    function automatic logic [63:0] ref_read(input logic [4:0] a, input int nregs);
        if (a == 5'd0 || int'(a) >= nregs) return 64'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    // One clock cycle: drive inputs, check the combinational outputs, advance the model at the edge.
    task automatic cyc(input bit r, input bit iv, input logic [31:0] ins, input bit st, input bit fl,
                       input bit we, input logic [4:0] wa, input logic [63:0] wd);
        exp_t c;
        logic [63:0] t;
        rst = r; in_valid = iv; instr = ins; ex_stall = st; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        exp_haz = occ_v && occ_mr && occ_rt != 5'd0 && iv &&
                  (occ_rt == ins[25:21] || occ_rt == ins[20:16]);
        acc = !st && !exp_haz;
        c.ctrl = ref_ctrl(ins[31:26]);
        t = ref_read(ins[25:21], 32); c.rd1a = 32'(t);
        t = ref_read(ins[20:16], 32); c.rd2a = 32'(t);
        c.rd1b = ref_read(ins[25:21], 8);
        c.rd2b = ref_read(ins[20:16], 8);
        t = ref_imm(ins); c.imma = 32'(t); c.immb = t;
        c.rs = ins[25:21]; c.rt = ins[20:16]; c.rd = ins[15:11];
        #1;
        haz_seen = a_hazard;
        rdy_seen = a_in_ready;
        if (known) begin
            check("hazard_a", a_hazard, exp_haz);
            check("hazard_b", b_hazard, exp_haz);
            check("in_ready_a", a_in_ready, acc);
            check("in_ready_b", b_in_ready, acc);
        end
        @(posedge clk);
        if (!r) begin
            foreach (mrf[i]) mrf[i] = 64'd0;
            sb.delete();
            occ_v = 0; occ_mr = 0; occ_rt = 5'd0; known = 1;
        end else begin
            if (!st) begin
                occ_v = iv && !fl && !exp_haz;
                occ_mr = occ_v && c.ctrl[5];
                occ_rt = c.rt;
                if (occ_v) sb.push_back(c);
            end else if (fl) begin
                if (occ_v) void'(sb.pop_back());
                occ_v = 0; occ_mr = 0;
            end
            if (we && wa != 5'd0) mrf[wa] = wd;
        end
        #1;
    endtask

    // Monitor: an entry leaves the scoreboard when the held result is taken downstream.
    always @(negedge clk) begin
        exp_t e;
        if (known) begin
            check("valid_a", a_out_valid, sb.size() > 0);
            check("valid_b", b_out_valid, sb.size() > 0);
            if (!a_out_valid) check("idle_ctrl_a", a_ctrl, 10'd0);
            if (!b_out_valid) check("idle_ctrl_b", b_ctrl, 10'd0);
            if (rst && !ex_stall && sb.size() > 0) begin
                e = sb.pop_front();
                check("ctrl_a", a_ctrl, e.ctrl);  check("ctrl_b", b_ctrl, e.ctrl);
                check("rd1_a", a_rd1, e.rd1a);    check("rd1_b", b_rd1, e.rd1b);
                check("rd2_a", a_rd2, e.rd2a);    check("rd2_b", b_rd2, e.rd2b);
                check("imm_a", a_imm, e.imma);    check("imm_b", b_imm, e.immb);
                check("rs_a", a_rs, e.rs);        check("rs_b", b_rs, e.rs);
                check("rt_a", a_rt, e.rt);        check("rt_b", b_rt, e.rt);
                check("rd_a", a_rd, e.rd);        check("rd_b", b_rd, e.rd);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [8];
        logic [5:0] op;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h23; ops[3] = 6'h2B;
        ops[4] = 6'h04; ops[5] = 6'h08; ops[6] = 6'h02; ops[7] = 6'($urandom);
        op = ops[$urandom_range(0, 7)];
        return {op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                5'($urandom_range(0, 15)), 11'($urandom)};
    endfunction

    initial begin
        logic [31:0] ins;
        bit          pend, r, iv, st, fl, we;
        rst = 0; in_valid = 0; instr = 0; ex_stall = 0; flush = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        occ_v = 0; occ_mr = 0; occ_rt = 0; known = 0;
        @(posedge clk); #1;
        cyc(0, 0, 32'h0, 0, 0, 0, 5'd0, 64'd0);
        cyc(0, 0, 32'h0, 0, 0, 0, 5'd0, 64'd0);
        check("reset_valid", a_out_valid, 0);
        check("reset_rd1", b_rd1, 0);

        // lw $2,4($1) with $1 written in the same cycle
        cyc(1, 1, 32'h8C220004, 0, 0, 1, 5'd1, 64'h10);
        check("lw_valid", a_out_valid, 1);
        check("lw_ctrl", a_ctrl, 10'b1101100000);
        check("lw_rd1", a_rd1, 32'h10);
        check("lw_imm", a_imm, 32'h4);
        check("lw_rt", a_rt, 5'd2);

        // dependent add: one bubble, then issue
        cyc(1, 1, 32'h00432020, 0, 0, 0, 5'd0, 64'd0);
        check("add_hazard", haz_seen, 1);
        check("add_in_ready", rdy_seen, 0);
        check("bubble_valid", a_out_valid, 0);
        check("bubble_ctrl", a_ctrl, 10'd0);
        cyc(1, 1, 32'h00432020, 0, 0, 0, 5'd0, 64'd0);
        check("add_hazard_gone", haz_seen, 0);
        check("add_valid", a_out_valid, 1);
        check("add_ctrl", a_ctrl, 10'b1000000110);

        cyc(1, 1, 32'h00A00000, 0, 0, 1, 5'd5, 64'hABCDEF);
        check("bypass_a", a_rd1, 32'hABCDEF);
        check("bypass_b", b_rd1, 64'hABCDEF);

        cyc(1, 0, 32'h0, 0, 0, 1, 5'd0, 64'hFFFF);
        cyc(1, 1, 32'h0, 0, 0, 0, 5'd0, 64'd0);
        check("r0_a", a_rd1, 0);
        check("r0_b", b_rd1, 0);
        cyc(1, 0, 32'h0, 0, 0, 1, 5'd9, 64'h1234);
        cyc(1, 1, 32'h01200000, 0, 0, 0, 5'd0, 64'd0);
        check("r9_a", a_rd1, 32'h1234);
        check("r9_b_out_of_range", b_rd1, 0);

        // addi $1,$0,-4 then stall three cycles with flush on the second
        cyc(1, 1, 32'h2001FFFC, 0, 0, 0, 5'd0, 64'd0);
        check("addi_ctrl", a_ctrl, 10'b1100000000);
        check("addi_imm_a", a_imm, 32'hFFFFFFFC);
        check("addi_imm_b", b_imm, 64'hFFFFFFFFFFFFFFFC);
        cyc(1, 1, 32'h8C630008, 1, 0, 0, 5'd0, 64'd0);
        check("stall_hold_valid", b_out_valid, 1);
        check("stall_hold_imm", b_imm, 64'hFFFFFFFFFFFFFFFC);
        check("stall_hold_ctrl", b_ctrl, 10'b1100000000);
        cyc(1, 1, 32'h8C630008, 1, 1, 0, 5'd0, 64'd0);
        check("stall_flush_valid", a_out_valid, 0);
        check("stall_flush_ctrl", a_ctrl, 10'd0);
        cyc(1, 1, 32'h8C630008, 1, 0, 0, 5'd0, 64'd0);
        check("post_flush_valid", a_out_valid, 0);
        check("post_flush_ctrl", b_ctrl, 10'd0);

        cyc(1, 1, 32'hFC000000, 0, 0, 0, 5'd0, 64'd0);
        check("op3f_valid", a_out_valid, 1);
        check("op3f_ctrl", a_ctrl, 10'd0);

        // reset during a hazard with stall, flush and write-back all asserted
        cyc(1, 1, 32'h8C220004, 0, 0, 0, 5'd0, 64'd0);
        cyc(0, 1, 32'h00432020, 1, 1, 1, 5'd3, 64'h55);
        check("rst_pre_hazard", haz_seen, 1);
        check("rst_valid", a_out_valid, 0);
        cyc(1, 1, 32'h00432020, 0, 0, 0, 5'd0, 64'd0);
        check("rst_hazard_clear", haz_seen, 0);
        check("rst_wb_dropped", a_rd2, 0);

        pend = 0; ins = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 99) >= 2;
            iv = pend ? 1'b1 : ($urandom_range(0, 9) < 8);
            if (!pend) ins = rand_instr();
            st = $urandom_range(0, 9) < 2;
            fl = $urandom_range(0, 9) == 0;
            we = $urandom_range(0, 1) == 1;
            cyc(r, iv, ins, st, fl, we, 5'($urandom_range(0, 15)), {$urandom, $urandom});
            pend = r && iv && !acc && !fl;
        end
        for (int n = 0; n < 3; n++) cyc(1, 0, 32'h0, 0, 0, 0, 5'd0, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
